mole_spawner: RTL and testbench

//  Responder side of the whac_a_mole_fsm mole/timeout handshake. It answers the FSM's

---
 rtl/mole_spawner_pkg.sv | 27 ++
 rtl/mole_spawner_if.sv | 28 ++
 rtl/mole_spawner_lfsr16.sv | 26 ++
 rtl/mole_spawner.sv | 153 +++++++++++++++
 tb/tb_mole_spawner.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mole_spawner_pkg.sv
// Shared definitions for the mole spawner: difficulty level codes, the default LED
// count and the state encodings of the spawn and window FSMs.
// Ports: none (package).
package whac_pkg;

    // Difficulty codes driven by the game FSM; any other code selects level 0.
    localparam logic [2:0] LVL_0 = 3'b000;
    localparam logic [2:0] LVL_1 = 3'b001;
    localparam logic [2:0] LVL_2 = 3'b010;
    localparam logic [2:0] LVL_3 = 3'b100;

    localparam int NUM_LEDS_DEF = 18;

    // Spawn FSM encoding.
    typedef logic [1:0] spawn_state_t;
    localparam spawn_state_t SP_IDLE     = 2'd0;
    localparam spawn_state_t SP_PICK     = 2'd1;
    localparam spawn_state_t SP_PRESENT  = 2'd2;
    localparam spawn_state_t SP_WAIT_LOW = 2'd3;

    // Window FSM encoding.
    typedef logic [1:0] win_state_t;
    localparam win_state_t TM_IDLE    = 2'd0;
    localparam win_state_t TM_RUN     = 2'd1;
    localparam win_state_t TM_EXPIRED = 2'd2;

endpackage

// File: rtl/mole_spawner_if.sv
// Mole/timeout handshake between the game FSM (master) and the mole spawner (slave).
// Signals:
//   ready_for_mole  master->slave  request a new mole (level, held)
//   timeout_start   master->slave  hit window active (level, held)
//   level_select    master->slave  difficulty code
//   led_number      slave->master  one-hot active mole
//   rng_ready       slave->master  one-cycle pulse, led_number valid
//   timeout         slave->master  1 = time remaining, 0 = expired
interface mole_spawner_if #(
    parameter int NUM_LEDS = 18
);
    logic                ready_for_mole;
    logic                timeout_start;
    logic [2:0]          level_select;
    logic [NUM_LEDS-1:0] led_number;
    logic                rng_ready;
    logic                timeout;

    modport master (
        output ready_for_mole, timeout_start, level_select,
        input  led_number, rng_ready, timeout
    );

    modport slave (
        input  ready_for_mole, timeout_start, level_select,
        output led_number, rng_ready, timeout
    );
endinterface

// File: rtl/mole_spawner_lfsr16.sv
// 16-bit free-running Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, loads seed
//   seed   in   16-bit reset value; zero is replaced by 16'h0001 (all-zero locks up)
//   q      out  current LFSR state
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed_eff;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end
endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: answers ready_for_mole with a pseudo-random one-hot LED plus a
// one-cycle rng_ready pulse, and answers timeout_start with a level-dependent
// hit window reported on timeout (1 = time left, 0 = expired).
// Ports:
//   clk    in      system clock
//   rst_n  in      asynchronous active-low reset
//   bus    slave   mole/timeout handshake (see mole_spawner_if)
module mole_spawner
    import whac_pkg::*;
#(
    parameter int          NUM_LEDS  = NUM_LEDS_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          WIN_L0    = 50_000_000,
    parameter int          WIN_L1    = 37_500_000,
    parameter int          WIN_L2    = 25_000_000,
    parameter int          WIN_L3    = 12_500_000,
    parameter int          CNT_W     = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    mole_spawner_if.slave  bus
);
    localparam logic [4:0]          N_LEDS   = 5'(NUM_LEDS);
    localparam logic [4:0]          LAST_IDX = 5'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] ONE_HOT0 = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- LFSR
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low five bits feed the index pick.
    assign lfsr_unused = ^lfsr_q[15:5];

    // ---------------------------------------------------------- index fold
    logic [4:0] raw_idx;
    logic [4:0] fold_idx;
    logic [4:0] pick_idx;
    logic [4:0] prev_idx;

    always_comb begin
        raw_idx  = lfsr_q[4:0];
        // raw < 32 and NUM_LEDS >= 16, so one subtraction brings it in range.
        fold_idx = (raw_idx >= N_LEDS) ? raw_idx - N_LEDS : raw_idx;
        // Step past the previous mole so the same LED never lights twice in a row.
        if (fold_idx == prev_idx) begin
            pick_idx = (prev_idx == LAST_IDX) ? 5'd0 : prev_idx + 5'd1;
        end else begin
            pick_idx = fold_idx;
        end
    end

    // ----------------------------------------------------------- spawn FSM
    spawn_state_t        sp_state;
    logic [NUM_LEDS-1:0] led_q;
    logic                rng_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_state <= SP_IDLE;
            led_q    <= '0;
            rng_q    <= 1'b0;
            prev_idx <= 5'd31;
        end else begin
            // NOTE: default first, overridden below in SP_PICK; the last
            // non-blocking assignment wins, so rng_ready is a single-cycle pulse.
            rng_q <= 1'b0;
            case (sp_state)
                SP_IDLE: begin
                    if (bus.ready_for_mole) sp_state <= SP_PICK;
                end
                SP_PICK: begin
                    if (!bus.ready_for_mole) begin
                        sp_state <= SP_IDLE;
                    end else begin
                        led_q    <= ONE_HOT0 << pick_idx;
                        prev_idx <= pick_idx;
                        rng_q    <= 1'b1;
                        sp_state <= SP_PRESENT;
                    end
                end
                SP_PRESENT: sp_state <= SP_WAIT_LOW;
                SP_WAIT_LOW: begin
                    if (!bus.ready_for_mole) sp_state <= SP_IDLE;
                end
                default: sp_state <= SP_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- window FSM
    win_state_t       tm_state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // Counter load value: window length minus one, so expiry lands on edge k+WIN.
    function automatic logic [CNT_W-1:0] win_load(input logic [2:0] lvl);
        case (lvl)
            LVL_1:   win_load = CNT_W'(WIN_L1 - 1);
            LVL_2:   win_load = CNT_W'(WIN_L2 - 1);
            LVL_3:   win_load = CNT_W'(WIN_L3 - 1);
            default: win_load = CNT_W'(WIN_L0 - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_state  <= TM_IDLE;
            cnt       <= '0;
            timeout_q <= 1'b1;
        end else begin
            case (tm_state)
                TM_IDLE: begin
                    timeout_q <= 1'b1;
                    // Level is captured into the count here; later level changes
                    // have no effect on this window.
                    if (bus.timeout_start) begin
                        cnt      <= win_load(bus.level_select);
                        tm_state <= TM_RUN;
                    end
                end
                TM_RUN: begin
                    if (!bus.timeout_start) begin
                        tm_state <= TM_IDLE;
                    end else if (cnt == '0) begin
                        timeout_q <= 1'b0;
                        tm_state  <= TM_EXPIRED;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TM_EXPIRED: begin
                    if (!bus.timeout_start) begin
                        timeout_q <= 1'b1;
                        tm_state  <= TM_IDLE;
                    end
                end
                default: tm_state <= TM_IDLE;
            endcase
        end
    end

    assign bus.led_number = led_q;
    assign bus.rng_ready  = rng_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner with short windows (20/15/10/5 cycles).
module tb_mole_spawner;
    import whac_pkg::*;

    localparam int          NL   = 18;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mole_spawner_if #(.NUM_LEDS(NL)) bus ();

    mole_spawner #(
        .NUM_LEDS  (NL),
        .LFSR_SEED (SEED),
        .WIN_L0    (20),
        .WIN_L1    (15),
        .WIN_L2    (10),
        .WIN_L3    (5),
        .CNT_W     (26)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR stepped from the polynomial; m_prev holds the value that
    // was current just before the most recent edge.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    int          m_prev_idx;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    function automatic int expect_idx(input logic [15:0] s, input int prev);
        int i;
        i = int'(s[4:0]) % NL;
        if (i == prev) i = (prev + 1) % NL;
        return i;
    endfunction

    // One spawn: raise request, check the pulse timing and LED, hold, drop.
    task automatic spawn(input int hold, input string tag);
        int                  e;
        int                  obs_idx;
        logic [NL-1:0]       exp_led;
        bus.ready_for_mole = 1'b1;
        @(negedge clk);
        check({tag, " rng_k"}, 32'(bus.rng_ready), 32'd0);
        @(negedge clk);
        e = expect_idx(m_prev, m_prev_idx);
        exp_led = '0;
        exp_led[e] = 1'b1;
        check({tag, " rng_k1"}, 32'(bus.rng_ready), 32'd1);
        check({tag, " led"}, 32'(bus.led_number), 32'(exp_led));
        check({tag, " onehot"}, 32'($onehot(bus.led_number)), 32'd1);
        obs_idx = -1;
        for (int b = 0; b < NL; b++) if (bus.led_number[b]) obs_idx = b;
        check({tag, " repeat"}, 32'(obs_idx == m_prev_idx), 32'd0);
        m_prev_idx = e;
        @(negedge clk);
        check({tag, " rng_k2"}, 32'(bus.rng_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " no_respawn"}, 32'(bus.rng_ready), 32'd0);
        end
        bus.ready_for_mole = 1'b0;
        @(negedge clk);
    endtask

    // Window: timeout_start held through edges k..k+drop, then released.
    // Expected timeout after edge k+j is 0 only while still held and j >= win.
    task automatic window(input logic [2:0] lvl, input int win, input int drop,
                          input logic [2:0] mid_lvl, input string tag);
        logic exp;
        bus.level_select  = lvl;
        bus.timeout_start = 1'b1;
        for (int j = 0; j <= drop + 2; j++) begin
            @(negedge clk);
            if (j == 1) bus.level_select = mid_lvl;
            exp = (j <= drop && j >= win) ? 1'b0 : 1'b1;
            check($sformatf("%s j=%0d", tag, j), 32'(bus.timeout), 32'(exp));
            if (j == drop) bus.timeout_start = 1'b0;
        end
    endtask

    initial begin
        logic [NL-1:0] last_led;

        rst_n              = 1'b0;
        bus.ready_for_mole = 1'b0;
        bus.timeout_start  = 1'b0;
        bus.level_select   = LVL_0;
        m_prev_idx         = 31;

        // 1: reset values, then quiet after release
        #12;
        check("rst led", 32'(bus.led_number), 32'd0);
        check("rst rng", 32'(bus.rng_ready), 32'd0);
        check("rst timeout", 32'(bus.timeout), 32'd1);
        check("rst lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle led", 32'(bus.led_number), 32'd0);
            check("idle rng", 32'(bus.rng_ready), 32'd0);
            check("idle timeout", 32'(bus.timeout), 32'd1);
        end

        // 2: first spawn, request held a while to show no re-spawn
        spawn(6, "first");

        // Abort: request dropped while in SP_PICK -> no pulse, LED unchanged
        last_led = bus.led_number;
        bus.ready_for_mole = 1'b1;
        @(negedge clk);
        bus.ready_for_mole = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort rng", 32'(bus.rng_ready), 32'd0);
            check("abort led", 32'(bus.led_number), 32'(last_led));
        end

        // 3: 200 spawns with random gaps and hold lengths
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            spawn(int'($urandom_range(0, 3)), "rand");
        end

        // 4: level 2 window expires at k+10 and holds; release restores timeout
        window(LVL_2, 10, 13, LVL_2, "win_l2");
        // 5: level 3 released early never expires
        window(LVL_3, 5, 2, LVL_3, "win_l3_hit");
        // illegal code -> level 0 length; mid-window level change ignored
        window(3'b011, 20, 22, LVL_3, "win_illegal");
        window(LVL_0, 20, 21, LVL_2, "win_l0");
        window(LVL_1, 15, 16, LVL_1, "win_l1");

        // Spawn and window running together
        fork
            spawn(2, "sim_spawn");
            window(LVL_3, 5, 7, LVL_3, "sim_win");
        join

        // 6a: reset while in SP_PICK
        bus.ready_for_mole = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_prev_idx = 31;
        #1;
        check("pick_rst rng", 32'(bus.rng_ready), 32'd0);
        check("pick_rst led", 32'(bus.led_number), 32'd0);
        check("pick_rst lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
        bus.ready_for_mole = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("pick_rst quiet", 32'(bus.rng_ready), 32'd0);
        end
        spawn(0, "post_rst");

        // 6b: reset with the window counter at 2 (level 2, after edge k+7)
        bus.level_select  = LVL_2;
        bus.timeout_start = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("run_rst pre", 32'(bus.timeout), 32'd1);
        end
        rst_n = 1'b0;
        bus.timeout_start = 1'b0;
        m_prev_idx = 31;
        #1;
        check("run_rst timeout", 32'(bus.timeout), 32'd1);
        check("run_rst lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("run_rst quiet", 32'(bus.timeout), 32'd1);
        end
        spawn(0, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
